// File: rtl/seq_multiplier_pkg.sv
// Shared constants, FSM encoding and operand helper for the sequential multiplier.
package seq_multiplier_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int ITERS     = 32;
  localparam int CNT_W     = 6;
  localparam int REG_W     = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Magnitude of an operand; 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [MUL_WIDTH-1:0] op_mag(input logic s, input logic [MUL_WIDTH-1:0] x);
    return (s && x[MUL_WIDTH-1]) ? -x : x;
  endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Request/result bundle between the issue stage and the multiplier, incl. register write port.
interface seq_multiplier_if;
  import seq_multiplier_pkg::*;

  logic                 start;
  logic                 signed_op;
  logic [MUL_WIDTH-1:0] a;
  logic [MUL_WIDTH-1:0] b;
  logic [REG_W-1:0]     dest;
  logic                 busy;
  logic                 done;
  logic [MUL_WIDTH-1:0] hi;
  logic [MUL_WIDTH-1:0] lo;
  logic                 regwr;
  logic [REG_W-1:0]     rd;
  logic [MUL_WIDTH-1:0] data;

  modport master (
    output start, signed_op, a, b, dest,
    input  busy, done, hi, lo, regwr, rd, data
  );

  modport slave (
    input  start, signed_op, a, b, dest,
    output busy, done, hi, lo, regwr, rd, data
  );
endinterface

// File: rtl/mult_ctrl.sv
// Multiplier sequencer: IDLE/RUN/DONE FSM with the shift-add iteration counter.
module mult_ctrl
  import seq_multiplier_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  output logic o_accept,
  output logic o_step,
  output logic o_last,
  output logic o_busy,
  output logic o_done
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          // Final step shares its edge with sign fix-up, so DONE lands in cycle 33
          if (r_cnt == CNT_W'(ITERS - 1)) begin
            r_state <= ST_DONE;
            r_cnt   <= '0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_accept = (r_state == ST_IDLE) && i_start;
  assign o_step   = (r_state == ST_RUN);
  assign o_last   = o_step && (r_cnt == CNT_W'(ITERS - 1));
  assign o_busy   = r_busy;
  assign o_done   = r_done;

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier, 32 iterations, signed via magnitude + final negate.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
)(
  input  logic             clk,
  input  logic             reset,
  seq_multiplier_if.slave  bus
);

  logic                 w_accept, w_step, w_last;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_mcand;
  logic                 r_neg;
  logic [REG_W-1:0]     r_dest;
  logic [WIDTH-1:0]     r_hi, r_lo, r_data;
  logic [REG_W-1:0]     r_rd;
  logic                 r_regwr;
  logic [WIDTH:0]       w_addend, w_sum;
  logic [2*WIDTH-1:0]   w_shift, w_prod;

  mult_ctrl u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .i_start  (bus.start),
    .o_accept (w_accept),
    .o_step   (w_step),
    .o_last   (w_last),
    .o_busy   (bus.busy),
    .o_done   (bus.done)
  );

  // Upper half accumulates with a carry bit that is shifted back in, so nothing is lost
  assign w_addend = r_acc[0] ? {1'b0, r_mcand} : '0;
  assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + w_addend;
  assign w_shift  = {w_sum, r_acc[WIDTH-1:1]};
  assign w_prod   = r_neg ? -w_shift : w_shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc   <= '0;
      r_mcand <= '0;
      r_neg   <= 1'b0;
      r_dest  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_data  <= '0;
      r_rd    <= '0;
      r_regwr <= 1'b0;
    end else begin
      r_regwr <= 1'b0;
      r_rd    <= '0;
      r_data  <= '0;
      if (w_accept) begin
        r_mcand <= op_mag(bus.signed_op, bus.a);
        r_acc   <= {{WIDTH{1'b0}}, op_mag(bus.signed_op, bus.b)};
        r_neg   <= bus.signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        r_dest  <= bus.dest;
      end
      if (w_step)
        r_acc <= w_shift;
      if (w_last) begin
        r_hi    <= w_prod[2*WIDTH-1:WIDTH];
        r_lo    <= w_prod[WIDTH-1:0];
        r_data  <= w_prod[WIDTH-1:0];
        r_rd    <= r_dest;
        r_regwr <= (r_dest != '0);
      end
    end
  end

  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;
  assign bus.data  = r_data;
  assign bus.rd    = r_rd;
  assign bus.regwr = r_regwr;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier with an expected-result queue and a small product model.
module tb_seq_multiplier;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [4:0]  rd;
    logic        regwr;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   stray = 0;
  exp_t q[$];

  seq_multiplier_if bus();

  seq_multiplier #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
    if (bus.regwr === 1'b1 && bus.done !== 1'b1) stray++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    ua = {32'b0, a};
    ub = {32'b0, b};
    return s ? 64'(sa * sb) : 64'(ua * ub);
  endfunction

  // Drive a request; caller is never near a rising edge. Operands are scrambled after acceptance.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d, input logic [63:0] exp);
    exp_t e;
    bus.start = 1'b1; bus.signed_op = s; bus.a = a; bus.b = b; bus.dest = d;
    e.hi = exp[63:32]; e.lo = exp[31:0]; e.rd = d; e.regwr = (d != 5'd0);
    q.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.signed_op = ~s; bus.a = $urandom; bus.b = $urandom; bus.dest = 5'($urandom);
  endtask

  // Entered in cycle n0 after the accepting edge; returns inside the DONE cycle.
  task automatic wait_done(input int n0, input string tag);
    int n;
    exp_t e;
    n = n0;
    while (bus.done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".latency"}, 64'(n), 64'd33);
    if (bus.done === 1'b1 && q.size() > 0) begin
      e = q.pop_front();
      chk({tag, ".hi"}, 64'(bus.hi), 64'(e.hi));
      chk({tag, ".lo"}, 64'(bus.lo), 64'(e.lo));
      chk({tag, ".data"}, 64'(bus.data), 64'(e.lo));
      chk({tag, ".rd"}, 64'(bus.rd), 64'(e.rd));
      chk({tag, ".regwr"}, 64'(bus.regwr), 64'(e.regwr));
      chk({tag, ".busy"}, 64'(bus.busy), 64'd1);
    end
  endtask

  task automatic finish_op(input string tag, input logic [63:0] hi, input logic [63:0] lo);
    @(posedge clk); #1;
    chk({tag, ".done_off"}, 64'(bus.done), 64'd0);
    chk({tag, ".busy_off"}, 64'(bus.busy), 64'd0);
    chk({tag, ".regwr_off"}, 64'(bus.regwr), 64'd0);
    chk({tag, ".hi_hold"}, 64'(bus.hi), hi);
    chk({tag, ".lo_hold"}, 64'(bus.lo), lo);
  endtask

  task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] d, input logic [63:0] exp);
    issue(s, a, b, d, exp);
    wait_done(1, tag);
    finish_op(tag, 64'(exp[63:32]), 64'(exp[31:0]));
  endtask

  initial begin
    int dc;
    logic [31:0] ra, rb;
    logic        rs;
    bus.start = 1'b0; bus.signed_op = 1'b0; bus.a = '0; bus.b = '0; bus.dest = '0;
    #1 reset = 1'b1;
    #1;
    chk("rst.busy", 64'(bus.busy), 64'd0);
    chk("rst.done", 64'(bus.done), 64'd0);
    chk("rst.regwr", 64'(bus.regwr), 64'd0);
    chk("rst.hi", 64'(bus.hi), 64'd0);
    chk("rst.lo", 64'(bus.lo), 64'd0);
    chk("rst.rd", 64'(bus.rd), 64'd0);
    chk("rst.data", 64'(bus.data), 64'd0);
    @(negedge clk) reset = 1'b0;

    // first start right after reset release
    run_op("u_ffff", 1'b0, 32'h0000FFFF, 32'h0000FFFF, 5'd5, 64'h00000000_FFFE0001);
    run_op("s_m1x3", 1'b1, 32'hFFFFFFFF, 32'h00000003, 5'd1, 64'hFFFFFFFF_FFFFFFFD);
    run_op("u_m1x3", 1'b0, 32'hFFFFFFFF, 32'h00000003, 5'd2, 64'h00000002_FFFFFFFD);
    run_op("s_min2", 1'b1, 32'h80000000, 32'h80000000, 5'd31, 64'h40000000_00000000);
    run_op("r0_7x6", 1'b0, 32'd7, 32'd6, 5'd0, 64'h00000000_0000002A);
    run_op("u_max2", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 64'hFFFFFFFE_00000001);
    for (int i = 0; i < 3; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom);
      run_op($sformatf("rnd%0d", i), rs, ra, rb, 5'(i + 10), model(rs, ra, rb));
    end

    // start while busy is dropped
    issue(1'b0, 32'h00001234, 32'h00000010, 5'd3, 64'h00000000_00012340);
    repeat (8) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.a = 32'd9; bus.b = 32'd9; bus.dest = 5'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(10, "busy_start");
    finish_op("busy_start", 64'd0, 64'h00012340);
    dc = done_cnt;
    repeat (40) @(posedge clk);
    #1;
    chk("busy_start.no_2nd_done", 64'(done_cnt), 64'(dc));
    chk("busy_start.idle", 64'(bus.busy), 64'd0);

    // start held through DONE is only taken in the following IDLE cycle
    issue(1'b0, 32'd100, 32'd3, 5'd6, 64'd300);
    wait_done(1, "done_start");
    bus.start = 1'b1; bus.signed_op = 1'b0; bus.a = 32'd5; bus.b = 32'd5; bus.dest = 5'd9;
    q.push_back('{32'd0, 32'd25, 5'd9, 1'b1});
    finish_op("done_start", 64'd0, 64'd300);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(1, "after_done");
    finish_op("after_done", 64'd0, 64'd25);

    // reset mid-operation
    issue(1'b0, 32'h11111111, 32'h2, 5'd7, 64'h00000000_22222222);
    repeat (14) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst.busy", 64'(bus.busy), 64'd0);
    chk("midrst.done", 64'(bus.done), 64'd0);
    chk("midrst.hi", 64'(bus.hi), 64'd0);
    chk("midrst.lo", 64'(bus.lo), 64'd0);
    chk("midrst.regwr", 64'(bus.regwr), 64'd0);
    q.delete();
    dc = done_cnt;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("midrst.no_done", 64'(done_cnt), 64'(dc));
    run_op("post_rst", 1'b0, 32'd2, 32'd3, 5'd4, 64'd6);
    chk("post_rst.one_done", 64'(done_cnt), 64'(dc + 1));
    chk("stray_regwr", 64'(stray), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand width; only 32 is required to work.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to begin a multiply.
REQ-005 SHALL have port signed_op, input, 1 bit: 1 means two's-complement operands, 0 means unsigned.
REQ-006 SHALL have port a, input, 32 bits: multiplicand, taken from the register file read port A.
REQ-007 SHALL have port b, input, 32 bits: multiplier, taken from the register file read port B.
REQ-008 SHALL have port dest, input, 5 bits: destination register index for the low word.
REQ-009 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-011 SHALL have ports hi and lo, output, 32 bits each: upper and lower words of the 64-bit product.
REQ-012 SHALL have ports regwr (output, 1 bit), rd (output, 5 bits) and data (output, 32 bits): the register file write port.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 In IDLE with start=1 at a rising edge, SHALL capture a, b, signed_op and dest, and move to RUN.
REQ-015 In IDLE, start=0 SHALL keep the block in IDLE.
REQ-016 In signed mode, SHALL capture operand magnitudes and record the result sign as the XOR of the two operand MSBs.
REQ-017 RUN SHALL perform one radix-2 shift-add step per cycle for exactly 32 cycles.
- A 6-bit iteration counter tracks the steps.
- The partial product uses a 64-bit accumulator with carry-out retained (no overflow loss).
REQ-018 After the 32nd step, SHALL apply the sign (negate the 64-bit value if required) and enter DONE.
REQ-019 DONE SHALL last exactly one cycle, then return to IDLE.
REQ-020 Latency: done SHALL be high in the 33rd cycle after the edge that accepted start.
REQ-021 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-022 In DONE, SHALL drive done=1, rd=captured dest and data=lo.
REQ-023 In DONE, regwr SHALL be 1 only if dest is not 0; a write to r0 is suppressed.
REQ-024 Outside DONE, SHALL drive done=0 and regwr=0.
REQ-025 hi and lo SHALL update only on entry to DONE and hold their value until the next DONE.
REQ-026 A start pulse arriving while busy=1 SHALL be ignored, with no queueing and no effect on the current operation.
REQ-027 A start asserted in the DONE cycle SHALL be ignored; a new operation may be accepted from the IDLE cycle that follows.
REQ-028 Operand changes on a and b after acceptance SHALL NOT affect the result.

Reset
REQ-029 Reset assertion SHALL immediately force the following, regardless of clock, including mid-operation: state IDLE; busy, done and regwr = 0; hi, lo, data and rd = 0; counter = 0.
REQ-030 An operation interrupted by reset SHALL produce no done pulse and no register write.
REQ-031 The first start SHALL be accepted on the first rising edge after reset deassertion.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (IDLE, RUN, DONE), WIDTH and the iteration count constant (32).
REQ-033 SHALL split into one sub-module, mult_ctrl (the FSM plus iteration counter), with the datapath in seq_multiplier.
REQ-034 SHALL build the datapath from the library's structural primitives where practical, consistent with the processor's gate-level style.

Verification
REQ-035 Bench SHALL apply unsigned 0x0000FFFF x 0x0000FFFF with dest=5; required: done at cycle 33, hi=0x00000000, lo=0xFFFE0001, regwr=1, rd=5.
REQ-036 Bench SHALL apply signed 0xFFFFFFFF x 0x00000003; required: hi=0xFFFFFFFF, lo=0xFFFFFFFD. Unsigned, same operands; required: hi=0x00000002, lo=0xFFFFFFFD.
REQ-037 Bench SHALL apply signed 0x80000000 x 0x80000000; required: hi=0x40000000, lo=0x00000000.
REQ-038 Bench SHALL apply 7 x 6 with dest=0; required: done pulses, lo=0x0000002A, regwr stays 0.
REQ-039 Bench SHALL apply start again at cycle 10 of a running operation with different operands; required: ignored, and the first result is unchanged at cycle 33.
REQ-040 Bench SHALL assert reset at cycle 15 of an operation; required: busy=0 and hi=lo=0 at once, no done pulse; a new 2 x 3 then gives lo=6.
